// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with one outstanding read, skid buffer, redirect and halt
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] PC_INC   = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_rvalid,
    output logic [15:0] instr_out,
    output logic [15:0] pc_out,
    output logic        valid_out,
    output logic        halted
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_WAIT   = 2'd1,
        S_DRAIN  = 2'd2,
        S_HALTED = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [15:0] pc;
    logic        skid_valid;
    logic [15:0] skid_instr;
    logic [15:0] skid_pc;

    logic deliver;
    logic is_halt;
    logic slot_free;

    assign deliver   = (state == S_WAIT) && imem_rvalid && !redirect;
    assign is_halt   = (imem_rdata[15:12] == 4'hF);
    assign slot_free = !valid_out || !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= state_next;
        end
    end

    // A response that raced a redirect in DRAIN still retires the outstanding read.
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH: begin
                if (!redirect && !skid_valid) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    state_next = imem_rvalid ? S_FETCH : S_DRAIN;
                end else if (imem_rvalid) begin
                    state_next = is_halt ? S_HALTED : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_next = S_FETCH;
                end
            end
            S_HALTED: begin
                if (redirect) begin
                    state_next = S_FETCH;
                end
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Request is suppressed under redirect so no read is left orphaned in FETCH.
    always_comb begin
        imem_req  = !reset && (state == S_FETCH) && !skid_valid && !redirect;
        imem_addr = pc;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc         <= RESET_PC;
            skid_valid <= 1'b0;
            skid_instr <= 16'h0000;
            skid_pc    <= 16'h0000;
            instr_out  <= 16'h0000;
            pc_out     <= 16'h0000;
            valid_out  <= 1'b0;
            halted     <= 1'b0;
        end else if (redirect) begin
            pc         <= redirect_pc;
            skid_valid <= 1'b0;
            valid_out  <= 1'b0;
            halted     <= 1'b0;
        end else begin
            if (deliver) begin
                if (!is_halt) begin
                    pc <= pc + PC_INC;
                end else begin
                    halted <= 1'b1;
                end
            end
            if (slot_free) begin
                if (skid_valid) begin
                    instr_out  <= skid_instr;
                    pc_out     <= skid_pc;
                    valid_out  <= 1'b1;
                    skid_valid <= deliver;
                    if (deliver) begin
                        skid_instr <= imem_rdata;
                        skid_pc    <= pc;
                    end
                end else if (deliver) begin
                    instr_out <= imem_rdata;
                    pc_out    <= pc;
                    valid_out <= 1'b1;
                end else begin
                    valid_out <= 1'b0;
                end
            end else if (deliver) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
                skid_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector bench for if_stage
module tb_if_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_rvalid;
    logic [15:0] instr_out;
    logic [15:0] pc_out;
    logic        valid_out;
    logic        halted;

    int errors = 0;
    int checks = 0;

    if_stage dut (
        .clk(clk),
        .reset(reset),
        .stall(stall),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_rvalid(imem_rvalid),
        .instr_out(instr_out),
        .pc_out(pc_out),
        .valid_out(valid_out),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [15:0] rpc;
        logic        rvalid;
        logic [15:0] rdata;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_instr;
        logic [15:0] e_pc;
        logic        e_halt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic r, input logic [15:0] rpc,
                       input logic rv, input logic [15:0] rd,
                       input logic req, input logic [15:0] addr, input logic vo,
                       input logic [15:0] ins, input logic [15:0] pco, input logic h);
        vec_t v;
        v.stall = s; v.redirect = r; v.rpc = rpc; v.rvalid = rv; v.rdata = rd;
        v.e_req = req; v.e_addr = addr; v.e_valid = vo;
        v.e_instr = ins; v.e_pc = pco; v.e_halt = h;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic check_outs(input int idx, input logic req, input logic [15:0] addr,
                              input logic vo, input logic [15:0] ins, input logic [15:0] pco,
                              input logic h);
        check("imem_req", idx, {15'd0, imem_req}, {15'd0, req});
        if (req) check("imem_addr", idx, imem_addr, addr);
        check("valid_out", idx, {15'd0, valid_out}, {15'd0, vo});
        check("instr_out", idx, instr_out, ins);
        check("pc_out", idx, pc_out, pco);
        check("halted", idx, {15'd0, halted}, {15'd0, h});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
        imem_rvalid = 1'b0; imem_rdata = 16'h0;

        //   stall red rpc      rv rdata     req addr     vo instr     pc       halt
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 16'h0000, 16'h0000, 0); // c0
        add(0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000, 0, 16'h0000, 16'h0000, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 1, 16'h1234, 16'h0000, 0);
        add(1, 0, 16'h0000, 1, 16'h2345, 0, 16'h0000, 0, 16'h1234, 16'h0000, 0); // stall x5
        add(1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 1, 16'h2345, 16'h0001, 0);
        add(1, 0, 16'h0000, 1, 16'h3456, 0, 16'h0000, 1, 16'h2345, 16'h0001, 0);
        add(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h2345, 16'h0001, 0);
        add(1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h2345, 16'h0001, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'h2345, 16'h0001, 0); // c8
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0003, 1, 16'h3456, 16'h0002, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h3456, 16'h0002, 0);
        add(0, 1, 16'h0040, 0, 16'h0000, 0, 16'h0000, 0, 16'h3456, 16'h0002, 0); // redirect in WAIT
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h3456, 16'h0002, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'h3456, 16'h0002, 0);
        add(0, 0, 16'h0000, 1, 16'h4567, 0, 16'h0000, 0, 16'h3456, 16'h0002, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 16'h3456, 16'h0002, 0); // c15
        add(0, 0, 16'h0000, 1, 16'h5555, 0, 16'h0000, 0, 16'h3456, 16'h0002, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0041, 1, 16'h5555, 16'h0040, 0);
        add(0, 1, 16'h0007, 1, 16'h6666, 0, 16'h0000, 0, 16'h5555, 16'h0040, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0007, 0, 16'h5555, 16'h0040, 0);
        add(0, 0, 16'h0000, 1, 16'hF000, 0, 16'h0000, 0, 16'h5555, 16'h0040, 0); // c20 HALT
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 1, 16'hF000, 16'h0007, 1);
        add(0, 0, 16'h0000, 1, 16'h1111, 0, 16'h0000, 0, 16'hF000, 16'h0007, 1);
        add(0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 16'hF000, 16'h0007, 1);
        add(0, 1, 16'h0010, 0, 16'h0000, 0, 16'h0000, 0, 16'hF000, 16'h0007, 1);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 0, 16'hF000, 16'h0007, 0); // c25
        add(0, 1, 16'hFFFF, 0, 16'h0000, 0, 16'h0000, 0, 16'hF000, 16'h0007, 0);
        add(0, 0, 16'h0000, 1, 16'h2222, 0, 16'h0000, 0, 16'hF000, 16'h0007, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFF, 0, 16'hF000, 16'h0007, 0);
        add(0, 0, 16'h0000, 1, 16'h7777, 0, 16'h0000, 0, 16'hF000, 16'h0007, 0);
        add(0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 1, 16'h7777, 16'hFFFF, 0); // c30 wrap

        #2;
        check_outs(-1, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            stall       = vecs[i].stall;
            redirect    = vecs[i].redirect;
            redirect_pc = vecs[i].rpc;
            imem_rvalid = vecs[i].rvalid;
            imem_rdata  = vecs[i].rdata;
            #1;
            check_outs(i, vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                       vecs[i].e_instr, vecs[i].e_pc, vecs[i].e_halt);
            @(negedge clk);
        end

        // Reset asserted mid-WAIT, off the clock edge; late response must be ignored.
        stall = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0; imem_rdata = 16'h0;
        #2 reset = 1'b1;
        #1 check_outs(100, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        reset = 1'b0; imem_rvalid = 1'b1; imem_rdata = 16'h9999;
        #1 check_outs(101, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1 check_outs(102, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        imem_rvalid = 1'b1; imem_rdata = 16'hABCD;
        #1 check_outs(103, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        @(negedge clk);
        imem_rvalid = 1'b0;
        #1 check_outs(104, 1'b1, 16'h0001, 1'b1, 16'hABCD, 16'h0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded on reset.
REQ-002 Parameter PC_INC, default 16'd1, PC increment per instruction (word addressing).
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 stall  input  1  downstream not ready; current output is held while high.
REQ-006 redirect  input  1  taken branch/jump this cycle.
REQ-007 redirect_pc  input  16  target PC, valid when redirect=1.
REQ-008 imem_req  output  1  instruction-memory read request, single-cycle pulse.
REQ-009 imem_addr  output  16  read address, valid when imem_req=1.
REQ-010 imem_rdata  input  16  instruction word, valid when imem_rvalid=1.
REQ-011 imem_rvalid  input  1  read response; earliest 1 cycle after imem_req, any latency after.
REQ-012 instr_out  output  16  fetched instruction to the IF/ID register.
REQ-013 pc_out  output  16  address of instr_out.
REQ-014 valid_out  output  1  instr_out/pc_out hold a real instruction; low means bubble.
REQ-015 halted  output  1  fetch stopped on a HALT instruction.

Function
REQ-016 Operation SHALL be a 4-state FSM: FETCH, WAIT, DRAIN, HALTED; at most one memory read outstanding.
REQ-017 FETCH with the skid buffer empty: imem_req=1, imem_addr=pc for that cycle, then go to WAIT.
REQ-018 FETCH with the skid buffer full: no request; remain in FETCH.
REQ-019 WAIT with imem_rvalid=1: deliver {imem_rdata, pc}; pc <= pc+PC_INC mod 2^16; go to FETCH.
REQ-020 WAIT with imem_rvalid=0: remain in WAIT.
REQ-021 Output slot (instr_out/pc_out/valid_out) registered; a slot is consumed on any cycle with valid_out=1 and stall=0.
REQ-022 Delivered word SHALL go to the output slot if it is empty or being consumed that cycle, else to a 1-entry skid buffer.
REQ-023 When the slot is consumed and the skid buffer is full, the skid entry SHALL move to the slot next cycle; the skid buffer empties.
REQ-024 While stall=1, instr_out/pc_out/valid_out SHALL not change (redirect excepted).
REQ-025 Slot consumed with nothing available: valid_out <= 0 next cycle; instr_out/pc_out keep their last values.
REQ-026 Minimum latency: imem_req in cycle N, imem_rvalid in N+1, valid_out high in N+2; peak throughput 1 instruction per 2 cycles.
REQ-027 Redirect (priority over stall and all else): pc <= redirect_pc, valid_out <= 0, skid buffer emptied, halted <= 0.
REQ-028 Redirect state transitions: WAIT with imem_rvalid=0 -> DRAIN; any other state, or WAIT with imem_rvalid=1 (response discarded) -> FETCH.
REQ-029 DRAIN: no request; on imem_rvalid=1 discard the response and go to FETCH.
REQ-030 A further redirect in DRAIN updates pc and stays in DRAIN.
REQ-031 Delivered word with instr[15:12]=4'hF (HALT): delivered normally, pc not incremented, state -> HALTED, halted <= 1.
REQ-032 HALTED: no requests; output slot/skid continue to drain; exit only on redirect (-> FETCH) or reset.
REQ-033 imem_rvalid while in FETCH or HALTED SHALL be ignored.

Reset
REQ-034 Reset SHALL force pc=RESET_PC, state=FETCH, skid empty, instr_out=0, pc_out=0, valid_out=0, imem_req=0, halted=0, regardless of clk.
REQ-035 Reset mid-WAIT SHALL abandon the outstanding read; a late imem_rvalid arriving in FETCH is ignored per REQ-033.
REQ-036 First imem_req SHALL occur on the first rising edge after reset deasserts.

Verification
REQ-037 Reset release; memory returns 16'h1234, 16'h2345 with 1-cycle latency -> imem_addr 0000, 0001; outputs {1234, 0000, valid}, then {2345, 0001, valid}.
REQ-038 stall=1 for 5 cycles while 2 responses arrive -> outputs frozen, skid full, no third request; on release both instructions out in order, no loss or duplication.
REQ-039 redirect with redirect_pc=16'h0040 while WAIT, rvalid 3 cycles later -> response discarded, valid_out 0, next imem_addr=0040.
REQ-040 Fetch of word 16'hF000 at pc 0007 -> delivered with pc_out 0007, halted=1, no further imem_req; redirect to 0010 -> halted=0, fetch at 0010.
REQ-041 pc=16'hFFFF fetch completes -> next imem_addr=0000.
REQ-042 Assert reset in WAIT, rvalid next cycle -> all outputs 0, response ignored, fetch restarts at RESET_PC.
